// File: rtl/spdif_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spdif_pkg : shared types for the S/PDIF sample scheduler         |
// | Revision  : 1.0                                                  |
// +------------------------------------------------------------------+
package spdif_pkg;

  localparam int SPDIF_SAMPLE_W = 32;

  typedef enum logic [1:0] {
    PREFILL = 2'd0,
    RUN     = 2'd1,
    MUTE    = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] l;
  } stereo_t;

endpackage
`default_nettype wire

// File: rtl/spdif_sched_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spdif_sched_fifo : synchronous FIFO, flush beats push and pop    |
// | Revision         : 1.0                                           |
// +------------------------------------------------------------------+
module spdif_sched_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW:0]   LVL_MAX = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push, do_pop;

  assign full_o  = (level_q == LVL_MAX);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      level_q <= level_q + LVL_ONE;
      else if (do_pop && !do_push) level_q <= level_q - LVL_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spdif_sample_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | spdif_sample_sched : source-select FIFO feeding S/PDIF samples   |
// | Revision           : 1.0                                         |
// +------------------------------------------------------------------+
module spdif_sample_sched
  import spdif_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int MUTE_REQS     = 4,
  parameter int UNDERRUN_ZERO = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sel_i,
  input  logic                          a_valid_i,
  output logic                          a_ready_o,
  input  logic [SPDIF_SAMPLE_W-1:0]     a_data_i,
  input  logic                          b_valid_i,
  output logic                          b_ready_o,
  input  logic [SPDIF_SAMPLE_W-1:0]     b_data_i,
  input  logic                          sample_req_i,
  output logic [15:0]                   audio_l_o,
  output logic [15:0]                   audio_r_o,
  output logic                          active_src_o,
  output logic                          muted_o,
  output logic                          underrun_o,
  output logic [15:0]                   underrun_cnt_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MUTE_REQS + 1);
  localparam logic [LW-1:0] LVL_HALF = LW'(FIFO_DEPTH / 2);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(MUTE_REQS - 1);

  sched_state_e state_q, state_d;
  logic          active_q, active_d;
  logic          sel_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   ucnt_q, ucnt_d;
  logic          under_q, under_d;
  stereo_t       audio_q, audio_d;
  logic          a_ready_q, a_ready_d, b_ready_q, b_ready_d;
  logic          muted_q, muted_d;

  logic                      src_valid, src_ready, push, pop, flush;
  logic                      fifo_full, fifo_empty;
  logic [SPDIF_SAMPLE_W-1:0] src_data, head;
  logic [LW-1:0]             level, level_nxt;

  assign src_valid = active_q ? b_valid_i : a_valid_i;
  assign src_data  = active_q ? b_data_i  : a_data_i;
  assign src_ready = active_q ? b_ready_q : a_ready_q;
  assign push      = src_valid && src_ready && !fifo_full;

  spdif_sched_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SPDIF_SAMPLE_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (src_data),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  // Pops are ignored here so ready stays independent of sample requests.
  assign level_nxt = level + LW'(push);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    ucnt_d   = ucnt_q;
    under_d  = 1'b0;
    audio_d  = audio_q;
    pop      = 1'b0;
    flush    = 1'b0;

    if (state_q != MUTE && sel_i != active_q) begin
      state_d = MUTE;
      flush   = 1'b1;
      cnt_d   = '0;
      if (sample_req_i) audio_d = '0;
    end else begin
      unique case (state_q)
        PREFILL: begin
          if (sample_req_i) audio_d = '0;
          if (level >= LVL_HALF) state_d = RUN;
        end
        RUN: begin
          if (sample_req_i) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              audio_d = head;
            end else begin
              under_d = 1'b1;
              if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
              if (UNDERRUN_ZERO != 0) audio_d = '0;
              state_d = PREFILL;
            end
          end
        end
        MUTE: begin
          if (sample_req_i) audio_d = '0;
          if (sel_i != sel_q) begin
            cnt_d = '0;
          end else if (sample_req_i) begin
            if (cnt_q == CNT_LAST) begin
              state_d  = PREFILL;
              active_d = sel_i;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = PREFILL;
      endcase
    end

    a_ready_d = (state_d != MUTE) && !active_d && (level_nxt < LVL_FULL);
    b_ready_d = (state_d != MUTE) &&  active_d && (level_nxt < LVL_FULL);
    muted_d   = (state_d != RUN);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= PREFILL;
      active_q  <= 1'b0;
      sel_q     <= 1'b0;
      cnt_q     <= '0;
      ucnt_q    <= '0;
      under_q   <= 1'b0;
      audio_q   <= '0;
      a_ready_q <= 1'b0;
      b_ready_q <= 1'b0;
      muted_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      sel_q     <= sel_i;
      cnt_q     <= cnt_d;
      ucnt_q    <= ucnt_d;
      under_q   <= under_d;
      audio_q   <= audio_d;
      a_ready_q <= a_ready_d;
      b_ready_q <= b_ready_d;
      muted_q   <= muted_d;
    end
  end

  assign a_ready_o      = a_ready_q;
  assign b_ready_o      = b_ready_q;
  assign audio_l_o      = audio_q.l;
  assign audio_r_o      = audio_q.r;
  assign active_src_o   = active_q;
  assign muted_o        = muted_q;
  assign underrun_o     = under_q;
  assign underrun_cnt_o = ucnt_q;
  assign level_o        = level;

endmodule
`default_nettype wire
